// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module   : alu
//  Purpose  : Execute-stage ALU. Single-cycle logic/arith ops plus iterative
//             signed MUL (shift-add) and DIV (restoring) behind start/busy/done.
//  Revision : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] c_OP_ADD = 5'd0;
  localparam logic [4:0] c_OP_SUB = 5'd1;
  localparam logic [4:0] c_OP_AND = 5'd2;
  localparam logic [4:0] c_OP_OR  = 5'd3;
  localparam logic [4:0] c_OP_XOR = 5'd4;
  localparam logic [4:0] c_OP_NOR = 5'd5;
  localparam logic [4:0] c_OP_SLT = 5'd6;
  localparam logic [4:0] c_OP_SLL = 5'd7;
  localparam logic [4:0] c_OP_SRL = 5'd8;
  localparam logic [4:0] c_OP_SRA = 5'd9;
  localparam logic [4:0] c_OP_LUI = 5'd10;
  localparam logic [4:0] c_OP_MOV = 5'd11;
  localparam logic [4:0] c_OP_BEQ = 5'd12;
  localparam logic [4:0] c_OP_BNE = 5'd13;
  localparam logic [4:0] c_OP_MUL = 5'd14;
  localparam logic [4:0] c_OP_DIV = 5'd15;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_MUL  = 3'd1;
  localparam logic [2:0] c_ST_DIV  = 3'd2;
  localparam logic [2:0] c_ST_FIX  = 3'd3;
  localparam logic [2:0] c_ST_DONE = 3'd4;

  localparam int c_MSB   = WIDTH - 1;
  localparam int c_CNT_W = $clog2(MUL_CYCLES > WIDTH ? MUL_CYCLES : WIDTH);
  localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(MUL_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(WIDTH - 1);

  logic [2:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  // Shared iterative datapath: r_x = multiplicand/divisor,
  // r_y = multiplier/quotient, r_acc = product/partial remainder.
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_acc;
  logic               r_neg_q;
  logic               r_neg_r;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_zero;
  logic               w_known;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_acc_add;
  logic [WIDTH-1:0]   w_prod;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign busy = (r_state == c_ST_MUL) || (r_state == c_ST_DIV) || (r_state == c_ST_FIX);
  assign done = (r_state == c_ST_DONE);

  assign w_mag_a   = a[c_MSB] ? -a : a;
  assign w_mag_b   = b[c_MSB] ? -b : b;
  assign w_acc_add = r_acc + (r_y[0] ? r_x : '0);
  assign w_prod    = r_neg_q ? -w_acc_add : w_acc_add;
  assign w_shift   = {r_acc, r_y[c_MSB]};
  assign w_trial   = w_shift - {1'b0, r_x};
  assign w_quo     = r_neg_q ? -r_y : r_y;
  assign w_rem     = r_neg_r ? -r_acc : r_acc;

  always_comb begin
    w_sum   = a + b;
    w_diff  = a - b;
    w_res   = '0;
    w_ovf   = 1'b0;
    w_known = 1'b1;
    case (aluop)
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (a[c_MSB] == b[c_MSB]) && (w_sum[c_MSB] != a[c_MSB]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (a[c_MSB] != b[c_MSB]) && (w_diff[c_MSB] != a[c_MSB]);
      end
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_XOR: w_res = a ^ b;
      c_OP_NOR: w_res = ~(a | b);
      c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      c_OP_SLL: w_res = b << shamt;
      c_OP_SRL: w_res = b >> shamt;
      c_OP_SRA: w_res = $signed(b) >>> shamt;
      c_OP_LUI: w_res = {b[15:0], {(WIDTH-16){1'b0}}};
      c_OP_MOV: w_res = b;
      c_OP_BEQ: w_res = w_diff;
      c_OP_BNE: w_res = w_diff;
      default:  w_known = 1'b0;
    endcase
    if (aluop == c_OP_BEQ)
      w_zero = (a == b);
    else if (aluop == c_OP_BNE)
      w_zero = (a != b);
    else
      w_zero = w_known && (w_res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result    <= '0;
      remainder <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (aluop == c_OP_MUL) begin
              r_x     <= w_mag_a;
              r_y     <= w_mag_b;
              r_acc   <= '0;
              r_neg_q <= a[c_MSB] ^ b[c_MSB];
              r_state <= c_ST_MUL;
            end else if (aluop == c_OP_DIV && b != '0) begin
              r_x     <= w_mag_b;
              r_y     <= w_mag_a;
              r_acc   <= '0;
              r_neg_q <= a[c_MSB] ^ b[c_MSB];
              r_neg_r <= a[c_MSB];
              r_state <= c_ST_DIV;
            end else if (aluop == c_OP_DIV) begin
              result    <= '1;
              remainder <= a;
              zero      <= 1'b0;
              overflow  <= 1'b0;
              r_state   <= c_ST_DONE;
            end else begin
              result    <= w_res;
              remainder <= '0;
              zero      <= w_zero;
              overflow  <= w_ovf;
              r_state   <= c_ST_DONE;
            end
          end
        end
        c_ST_MUL: begin
          r_acc <= w_acc_add;
          r_x   <= r_x << 1;
          r_y   <= r_y >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_MUL_LAST) begin
            result    <= w_prod;
            remainder <= '0;
            zero      <= (w_prod == '0);
            overflow  <= 1'b0;
            r_state   <= c_ST_DONE;
          end
        end
        c_ST_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          // Restore by keeping the shifted value when the trial goes negative.
          if (!w_trial[WIDTH]) begin
            r_acc <= w_trial[c_MSB:0];
            r_y   <= {r_y[c_MSB-1:0], 1'b1};
          end else begin
            r_acc <= w_shift[c_MSB:0];
            r_y   <= {r_y[c_MSB-1:0], 1'b0};
          end
          if (r_cnt == c_DIV_LAST)
            r_state <= c_ST_FIX;
        end
        c_ST_FIX: begin
          result    <= w_quo;
          remainder <= w_rem;
          zero      <= (w_quo == '0);
          overflow  <= 1'b0;
          r_state   <= c_ST_DONE;
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu
//  Purpose  : Scoreboard bench for alu: arithmetic reference model, queue of
//             expected completions, monitor keyed on done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  localparam logic [4:0] c_ADD = 5'd0,  c_SUB = 5'd1,  c_SLL = 5'd7,  c_SRA = 5'd9;
  localparam logic [4:0] c_LUI = 5'd10, c_BEQ = 5'd12, c_BNE = 5'd13;
  localparam logic [4:0] c_MUL = 5'd14, c_DIV = 5'd15;

  logic        clk, rst, start;
  logic [4:0]  aluop, shamt;
  logic [31:0] a, b, result, remainder;
  logic        zero, overflow, busy, done;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        z;
    logic        ovf;
    int          cyc;
    int          bsy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_run = 0;
  logic prev_done = 1'b0;

  alu #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a), .b(b),
    .shamt(shamt), .result(result), .remainder(remainder), .zero(zero),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: exact 64-bit signed arithmetic, truncated to 32 bits.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] x, y,
                                 input logic [4:0] sh, input int now);
    exp_t   e;
    longint sx, sy, t, t2;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.rem = '0; e.ovf = 1'b0; e.cyc = now + 1; e.bsy = 0;
    case (op)
      5'd0:  begin t = sx + sy; e.res = t[31:0]; e.ovf = (t != longint'($signed(e.res))); end
      5'd1:  begin t = sx - sy; e.res = t[31:0]; e.ovf = (t != longint'($signed(e.res))); end
      5'd2:  e.res = x & y;
      5'd3:  e.res = x | y;
      5'd4:  e.res = x ^ y;
      5'd5:  e.res = ~(x | y);
      5'd6:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      5'd7:  e.res = y << sh;
      5'd8:  e.res = y >> sh;
      5'd9:  begin t = sy >>> sh; e.res = t[31:0]; end
      5'd10: e.res = y * 32'd65536;
      5'd11: e.res = y;
      5'd12, 5'd13: begin t = sx - sy; e.res = t[31:0]; end
      5'd14: begin t = sx * sy; e.res = t[31:0]; e.cyc = now + 33; e.bsy = 32; end
      5'd15: begin
        if (y == 32'd0) begin
          e.res = 32'hFFFF_FFFF; e.rem = x;
        end else begin
          t = sx / sy; t2 = sx % sy;
          e.res = t[31:0]; e.rem = t2[31:0]; e.cyc = now + 34; e.bsy = 33;
        end
      end
      default: e.res = '0;
    endcase
    if (op == c_BEQ)      e.z = (x == y);
    else if (op == c_BNE) e.z = (x != y);
    else if (op > 5'd15)  e.z = 1'b0;
    else                  e.z = (e.res == 32'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_single_pulse", {31'b0, prev_done}, 32'd0);
        check("busy_low_in_done", {31'b0, busy}, 32'd0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          check("result", result, mon_e.res);
          check("remainder", remainder, mon_e.rem);
          check("zero", {31'b0, zero}, {31'b0, mon_e.z});
          check("overflow", {31'b0, overflow}, {31'b0, mon_e.ovf});
          check("done_cycle", cyc, mon_e.cyc);
          check("busy_cycles", busy_run, mon_e.bsy);
        end
        busy_run = 0;
      end else if (busy) begin
        busy_run++;
      end
      prev_done = done;
    end
  end

  // Issue one op; inputs are scrambled after launch, and optionally a stray
  // start is pulsed 'poke' cycles later while the unit should be busy.
  task automatic run_op(input logic [4:0] op, input logic [31:0] xa, xb,
                        input logic [4:0] sh, input int poke);
    bit got;
    @(posedge clk); #1;
    start = 1'b1; aluop = op; a = xa; b = xb; shamt = sh;
    q.push_back(model(op, xa, xb, sh, cyc));
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      start = (poke != 0 && k == poke);
      aluop = 5'($urandom_range(0, 13));
      a = $urandom; b = $urandom; shamt = 5'($urandom);
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected completion of op %0d", op);
      q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  int n_done;

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; aluop = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_result", result, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_flags", {28'b0, zero, overflow, busy, done}, 32'd0);
    rst = 1'b0;

    run_op(c_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
    run_op(c_SUB, 32'h8000_0000, 32'd1, 5'd0, 0);
    run_op(c_SRA, 32'd0, 32'h8000_0000, 5'd4, 0);
    run_op(c_SLL, 32'd0, 32'h8000_0000, 5'd4, 0);
    run_op(c_LUI, 32'd0, 32'h0000_1234, 5'd0, 0);
    run_op(c_MUL, 32'hFFFF_FFFF, 32'd3, 5'd0, 0);
    run_op(c_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
    run_op(c_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 0);
    run_op(c_DIV, 32'd5, 32'd0, 5'd0, 0);
    run_op(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 0);
    run_op(c_BEQ, 32'd9, 32'd9, 5'd0, 0);
    run_op(c_BNE, 32'd9, 32'd9, 5'd0, 0);
    run_op(5'd20, 32'd1, 32'd2, 5'd0, 0);
    run_op(c_MUL, 32'd12345, 32'hFFFF_FD5A, 5'd0, 5);

    for (int i = 0; i < 60; i++)
      run_op(5'($urandom_range(0, 17)), pick(), pick(), 5'($urandom), 0);

    // Reset in the middle of a divide: nothing must complete.
    @(posedge clk); #1;
    start = 1'b1; aluop = c_DIV; a = 32'hFFFF_FF9C; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    check("busy_before_rst", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("no_done_after_rst", n_done, 32'd0);
    run_op(c_ADD, 32'd2, 32'd3, 5'd0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
